// File: rtl/dut_stim_pkg.sv
// Shared types and frame-geometry helpers for the DSP test-DUT byte-stream driver.
package dut_stim_pkg;

    typedef enum logic [1:0] {
        RECV   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        SEND   = 2'd3
    } state_t;

    localparam int CTRL_SIGNED = 0;
    localparam int CTRL_ADDSUB = 1;
    localparam int CTRL_CIN    = 2;
    localparam int CTRL_LOADC  = 3;
    localparam int CTRL_CEOUT  = 4;
    localparam int CTRL_RSTOUT = 5;
    localparam int CTRL_BITS   = 6;

    function automatic int byte_count(input int width);
        return (width + 7) / 8;
    endfunction

    function automatic int rx_frame_len(input int a_w, input int c_w);
        return 1 + 2 * byte_count(a_w) + byte_count(c_w);
    endfunction

endpackage

// File: rtl/dut_stim_capture.sv
// Receives a stimulus frame, drives the DSP DUT operands, strobes it once,
// captures z after a fixed latency and returns it as a byte frame.
//
// state  | meaning
// RECV   | accepting stimulus bytes into the shadow registers
// STROBE | one-cycle DUT qualifier, latency counter loaded
// WAIT   | counting down to the z sample point
// SEND   | returning the captured z, LSB byte first
module dut_stim_capture
    import dut_stim_pkg::*;
#(
    parameter int A_W     = 18,
    parameter int C_W     = 54,
    parameter int Z_W     = 54,
    parameter int LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    output logic           rx_ready,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic [A_W-1:0] a,
    output logic [A_W-1:0] b,
    output logic [C_W-1:0] c,
    output logic           is_signed,
    output logic           addsub,
    output logic           cin,
    output logic           loadc,
    output logic           ceout,
    output logic           rstout,
    output logic           strobe,
    input  logic [Z_W-1:0] z,
    output logic           busy
);

    localparam int AB       = byte_count(A_W);
    localparam int CB       = byte_count(C_W);
    localparam int ZB       = byte_count(Z_W);
    localparam int RXB      = rx_frame_len(A_W, C_W);
    localparam int RX_CNT_W = $clog2(RXB);
    localparam int TX_CNT_W = $clog2(ZB);

    localparam logic [RX_CNT_W-1:0] B_FIRST = RX_CNT_W'(1 + AB);
    localparam logic [RX_CNT_W-1:0] C_FIRST = RX_CNT_W'(1 + 2 * AB);
    localparam logic [RX_CNT_W-1:0] RX_LAST = RX_CNT_W'(RXB - 1);
    localparam logic [TX_CNT_W-1:0] TX_LAST = TX_CNT_W'(ZB - 1);
    localparam logic [3:0]          WAIT_LOAD = 4'(LATENCY);

    state_t                state;
    logic [RX_CNT_W-1:0]   rx_cnt;
    logic [TX_CNT_W-1:0]   tx_cnt;
    logic [3:0]            wait_cnt;
    logic [CTRL_BITS-1:0]  ctrl_sh;
    logic [8*AB-1:0]       a_sh;
    logic [8*AB-1:0]       b_sh;
    logic [8*CB-1:0]       c_sh;
    logic [8*CB-1:0]       c_full;
    logic [8*ZB-1:0]       z_ext;
    logic [8*ZB-1:0]       cap;
    logic                  unused_pad;

    // The last frame byte is the top byte of c, so it bypasses the shadow
    // to let every DUT-facing output load on the same edge.
    assign c_full  = {rx_data, c_sh[8*CB-1:8]};
    assign tx_data = cap[7:0];

    // Pad bits above the field widths are deliberately discarded.
    assign unused_pad = ^{c_full, c_sh[7:0]};

    always_comb begin
        z_ext          = '0;
        z_ext[Z_W-1:0] = z;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RECV;
            rx_cnt    <= '0;
            tx_cnt    <= '0;
            wait_cnt  <= '0;
            ctrl_sh   <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            c_sh      <= '0;
            cap       <= '0;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            is_signed <= 1'b0;
            addsub    <= 1'b0;
            cin       <= 1'b0;
            loadc     <= 1'b0;
            ceout     <= 1'b0;
            rstout    <= 1'b0;
            strobe    <= 1'b0;
            tx_valid  <= 1'b0;
            rx_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                RECV: begin
                    if (rx_valid) begin
                        if (rx_cnt == '0)
                            ctrl_sh <= rx_data[CTRL_BITS-1:0];
                        else if (rx_cnt < B_FIRST)
                            a_sh <= {rx_data, a_sh[8*AB-1:8]};
                        else if (rx_cnt < C_FIRST)
                            b_sh <= {rx_data, b_sh[8*AB-1:8]};
                        else
                            c_sh <= {rx_data, c_sh[8*CB-1:8]};

                        if (rx_cnt == RX_LAST) begin
                            rx_cnt    <= '0;
                            a         <= a_sh[A_W-1:0];
                            b         <= b_sh[A_W-1:0];
                            c         <= c_full[C_W-1:0];
                            is_signed <= ctrl_sh[CTRL_SIGNED];
                            addsub    <= ctrl_sh[CTRL_ADDSUB];
                            cin       <= ctrl_sh[CTRL_CIN];
                            loadc     <= ctrl_sh[CTRL_LOADC];
                            ceout     <= ctrl_sh[CTRL_CEOUT];
                            rstout    <= ctrl_sh[CTRL_RSTOUT];
                            strobe    <= 1'b1;
                            rx_ready  <= 1'b0;
                            busy      <= 1'b1;
                            state     <= STROBE;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                end
                STROBE: begin
                    strobe   <= 1'b0;
                    wait_cnt <= WAIT_LOAD;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        cap      <= z_ext;
                        wait_cnt <= '0;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        cap <= {8'h00, cap[8*ZB-1:8]};
                        if (tx_cnt == TX_LAST) begin
                            tx_cnt   <= '0;
                            tx_valid <= 1'b0;
                            rx_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= RECV;
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end
                end
                default: state <= RECV;
            endcase
        end
    end

endmodule

// File: tb/tb_dut_stim_capture.sv
// Scoreboard bench for dut_stim_capture: two instances (LATENCY 1 and 3) driven
// in turn, each facing a z model that loads a*b+c on strobe and then drifts every cycle.
module tb_dut_stim_capture;

    localparam logic [53:0] K = 54'h0123_4567_89AB;

    typedef struct packed {
        logic [5:0]  ctl;
        logic [17:0] a;
        logic [17:0] b;
        logic [53:0] c;
    } out_t;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] rx_data;
    logic rx_valid;
    logic tx_ready;
    int   sel;

    logic        rx_valid_v[2];
    logic        rx_ready_o[2], tx_valid_o[2], strobe_o[2], busy_o[2];
    logic [7:0]  tx_data_o[2];
    logic [17:0] a_o[2], b_o[2];
    logic [53:0] c_o[2], z_i[2];
    logic        is_signed_o[2], addsub_o[2], cin_o[2], loadc_o[2], ceout_o[2], rstout_o[2];

    out_t       exp_out_q[$];
    logic [7:0] exp_tx_q[$];
    out_t       cur_out[2];
    logic       prev_strobe[2];
    int strobe_cnt[2], rxacc[2], txbytes[2], frames_done[2];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign rx_valid_v[g] = rx_valid && (sel == g);
        dut_stim_capture #(.LATENCY(g == 0 ? 1 : 3)) dut (
            .clk(clk), .rst(rst),
            .rx_data(rx_data), .rx_valid(rx_valid_v[g]), .rx_ready(rx_ready_o[g]),
            .tx_data(tx_data_o[g]), .tx_valid(tx_valid_o[g]), .tx_ready(tx_ready),
            .a(a_o[g]), .b(b_o[g]), .c(c_o[g]),
            .is_signed(is_signed_o[g]), .addsub(addsub_o[g]), .cin(cin_o[g]),
            .loadc(loadc_o[g]), .ceout(ceout_o[g]), .rstout(rstout_o[g]),
            .strobe(strobe_o[g]), .z(z_i[g]), .busy(busy_o[g])
        );
    end

    // Environment DUT model: registered a*b+c on strobe, then changes every cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst)
                z_i[i] <= '0;
            else if (strobe_o[i])
                z_i[i] <= 54'(a_o[i]) * 54'(b_o[i]) + c_o[i];
            else
                z_i[i] <= z_i[i] + K;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        tests++;
        fails++;
        $display("FAIL %s: got %0d, required event did not occur as expected", name, act);
    endtask

    function automatic out_t dut_out(input int i);
        out_t o;
        o.ctl = {rstout_o[i], ceout_o[i], loadc_o[i], cin_o[i], addsub_o[i], is_signed_o[i]};
        o.a   = a_o[i];
        o.b   = b_o[i];
        o.c   = c_o[i];
        return o;
    endfunction

    // Reference model: decode fields from raw frame bytes, predict z at the sample point.
    task automatic push_expect(input logic [7:0] fr[14], input int lat);
        out_t        e;
        logic [23:0] a24, b24;
        logic [55:0] c56, z56;
        logic [53:0] zexp;
        a24   = {fr[3], fr[2], fr[1]};
        b24   = {fr[6], fr[5], fr[4]};
        c56   = {fr[13], fr[12], fr[11], fr[10], fr[9], fr[8], fr[7]};
        e.ctl = fr[0][5:0];
        e.a   = a24[17:0];
        e.b   = b24[17:0];
        e.c   = c56[53:0];
        zexp  = 54'(e.a) * 54'(e.b) + e.c + 54'(lat - 1) * K;
        z56   = {2'b00, zexp};
        exp_out_q.push_back(e);
        for (int k = 0; k < 7; k++) exp_tx_q.push_back(z56[8*k +: 8]);
        frames_done[sel]++;
    endtask

    task automatic send_frame(input logic [7:0] fr[14], input int n, input int gap_pct, input bit rand_tx);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int budget;
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                rx_valid = 1'b0;
                if (rand_tx) tx_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
            rx_data  = fr[i];
            rx_valid = 1'b1;
            acc      = 1'b0;
            budget   = 0;
            while (!acc && budget < 300) begin
                if (rand_tx) tx_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                acc = rx_ready_o[sel];
                if (acc && i == 13) push_expect(fr, (sel == 1) ? 3 : 1);
                @(posedge clk); #1;
                budget++;
            end
            if (!acc) begin
                fail_now("rx_timeout", i);
                return;
            end
        end
    endtask

    task automatic wait_idle(input bit rand_tx);
        int budget;
        bit done;
        budget = 0;
        done   = 1'b0;
        while (!done && budget < 500) begin
            if (rand_tx) tx_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            done = !busy_o[sel] && exp_tx_q.size() == 0;
            @(posedge clk); #1;
            budget++;
        end
        tx_ready = 1'b1;
        check("drain_done", done, 1);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                cur_out[i]     = '0;
                prev_strobe[i] = 1'b0;
                rxacc[i]       = 0;
                txbytes[i]     = 0;
            end else begin
                if (strobe_o[i]) begin
                    check("strobe_width", prev_strobe[i], 0);
                    if (exp_out_q.size() == 0) begin
                        fail_now("strobe_unexpected", strobe_cnt[i]);
                    end else begin
                        out_t e;
                        e = exp_out_q.pop_front();
                        check("staged_outputs", dut_out(i), e);
                        cur_out[i] = e;
                    end
                    strobe_cnt[i]++;
                end else begin
                    check("outputs_hold", dut_out(i), cur_out[i]);
                end
                prev_strobe[i] = strobe_o[i];
                if (tx_valid_o[i] && tx_ready) begin
                    if (exp_tx_q.size() == 0) fail_now("tx_unexpected", int'(tx_data_o[i]));
                    else check("tx_byte", tx_data_o[i], exp_tx_q.pop_front());
                    txbytes[i]++;
                end
                if (rx_valid_v[i] && rx_ready_o[i]) begin
                    check("rx_after_tx", txbytes[i], 7 * (rxacc[i] / 14));
                    rxacc[i]++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] fr[14];
        int   sc;
        int   budget;
        out_t o;

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_outputs", dut_out(i), '0);
            check("rst_strobe", strobe_o[i], 0);
            check("rst_tx_valid", tx_valid_o[i], 0);
            check("rst_tx_data", tx_data_o[i], 0);
            check("rst_busy", busy_o[i], 0);
        end
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_rx_ready0", rx_ready_o[0], 1);
        check("rst_rx_ready1", rx_ready_o[1], 1);
        @(posedge clk); #1;

        // Directed frame a=3, b=5, ceout, with a 10-cycle tx stall.
        fr = '{8'h10, 8'h03, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sc = strobe_cnt[0];
        tx_ready = 1'b0;
        send_frame(fr, 14, 0, 0);
        check("t1_strobe_now", strobe_o[0], 1);
        check("t1_a", a_o[0], 18'd3);
        check("t1_b", b_o[0], 18'd5);
        check("t1_ceout", ceout_o[0], 1);
        rx_data = 8'hAA; rx_valid = 1'b1;
        budget = 0;
        do begin @(negedge clk); budget++; end while (!tx_valid_o[0] && budget < 20);
        check("t1_tx_valid_seen", tx_valid_o[0], 1);
        repeat (10) begin
            @(negedge clk);
            check("stall_tx_data", tx_data_o[0], 8'h0F);
            check("stall_rx_ready", rx_ready_o[0], 0);
            check("stall_busy", busy_o[0], 1);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        wait_idle(0);
        check("t1_one_strobe", strobe_cnt[0] - sc, 1);

        // All-ones control byte and a with pad bits set.
        for (int i = 0; i < 14; i++) fr[i] = 8'($urandom);
        fr[0] = 8'hFF; fr[1] = 8'hFF; fr[2] = 8'hFF; fr[3] = 8'hFF;
        send_frame(fr, 14, 30, 0);
        o = dut_out(0);
        check("t2_a_masked", o.a, 18'h3FFFF);
        check("t2_ctl_all", o.ctl, 6'h3F);
        rx_valid = 1'b0;
        wait_idle(0);

        // Reset after byte 7 discards the partial frame.
        for (int i = 0; i < 14; i++) fr[i] = 8'($urandom);
        send_frame(fr, 8, 0, 0);
        rx_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst_outputs", dut_out(0), '0);
        check("arst_strobe", strobe_o[0], 0);
        check("arst_tx_valid", tx_valid_o[0], 0);
        check("arst_tx_data", tx_data_o[0], 0);
        check("arst_busy", busy_o[0], 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        sc = strobe_cnt[0];
        for (int i = 0; i < 14; i++) fr[i] = 8'($urandom);
        send_frame(fr, 14, 0, 0);
        rx_valid = 1'b0;
        wait_idle(0);
        check("post_rst_one_strobe", strobe_cnt[0] - sc, 1);

        // Back-to-back frames with rx_valid held high throughout.
        sc = strobe_cnt[0];
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 14; i++) fr[i] = 8'($urandom);
            send_frame(fr, 14, 0, 0);
        end
        rx_valid = 1'b0;
        wait_idle(0);
        check("b2b_two_strobes", strobe_cnt[0] - sc, 2);

        // Random frames, idle gaps and tx back-pressure.
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 14; i++) fr[i] = 8'($urandom);
            send_frame(fr, 14, 25, 1);
            if ($urandom_range(0, 1) == 0) rx_valid = 1'b0;
        end
        rx_valid = 1'b0;
        wait_idle(1);

        // LATENCY=3 instance: captured z must be the value present in S+3.
        sel = 1;
        @(posedge clk); #1;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 14; i++) fr[i] = 8'($urandom);
            send_frame(fr, 14, 20, 1);
        end
        rx_valid = 1'b0;
        wait_idle(1);

        check("final_out_q_empty", exp_out_q.size(), 0);
        check("final_tx_q_empty", exp_tx_q.size(), 0);
        check("strobes_l1", strobe_cnt[0], frames_done[0]);
        check("strobes_l3", strobe_cnt[1], frames_done[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dut_stim_capture.md
Name: dut_stim_capture

Overview:
- Host-side byte-stream driver for the DSP hardware-test DUTs (MULTADDSUB18X18 wrappers with a `strobe` qualifier).
- Receives a fixed-length stimulus frame over a valid/ready byte stream and drives `a`/`b`/`c` and the control bits. It then issues a one-cycle `strobe`, waits a programmed latency, captures `z`, and transmits it back as a byte frame.
- Sits between the board UART/JTAG byte bridge and `dut`.

Parameters:
- A_W, 18, width of `a` and `b`.
- C_W, 54, width of `c`.
- Z_W, 54, width of `z`.
- LATENCY, 1, cycles from the strobe cycle to the cycle in which `z` is sampled; legal range 1..15.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  stimulus byte.
- rx_valid  in  1  `rx_data` valid.
- rx_ready  out  1  block accepts a byte.
- tx_data  out  8  result byte.
- tx_valid  out  1  `tx_data` valid.
- tx_ready  in  1  sink accepts a byte.
- a, b  out  A_W  DUT operands.
- c  out  C_W  DUT addend.
- is_signed, addsub, cin, loadc, ceout, rstout  out  1 each  DUT control bits.
- strobe  out  1  one-cycle DUT qualifier.
- z  in  Z_W  DUT result.
- busy  out  1  high whenever the state is not RECV.

Behaviour:
- Byte counts:
  - AB = ceil(A_W/8) = 3, CB = ceil(C_W/8) = 7, ZB = ceil(Z_W/8) = 7.
  - RX frame is 1+2·AB+CB = 14 bytes; TX frame is ZB = 7 bytes.
- RX frame order and field mapping:
  - Byte 0 is the control byte: bit0 `is_signed`, bit1 `addsub`, bit2 `cin`, bit3 `loadc`, bit4 `ceout`, bit5 `rstout`; bits 7:6 are ignored.
  - Then `a` LSB-first (AB bytes), `b` LSB-first (AB bytes), `c` LSB-first (CB bytes).
  - Bits beyond the field width in a field's top byte are ignored.
- Stimulus staging:
  - Bytes assemble into shadow registers.
  - DUT-facing outputs update together, in one cycle, only when the last RX byte is accepted. They are never partially updated mid-frame.
  - Outputs then hold until the next frame completes.
- FSM states:
  - RECV: `rx_ready`=1. A byte transfers on `rx_valid`&&`rx_ready`. The byte counter increments; on the last byte, shadow registers copy to the outputs → STROBE.
  - STROBE: `strobe`=1 for exactly this one cycle; load the wait counter with LATENCY → WAIT.
  - WAIT: decrement the counter each cycle. In the cycle the counter reads 1, sample `z` into the capture register at that clock edge → SEND.
  - SEND:
    - `tx_valid`=1 with `tx_data` = capture byte[k], k = 0..ZB-1, LSB-first; the top byte is zero-extended beyond Z_W.
    - `tx_data` is stable while `tx_valid`&&!`tx_ready`.
    - k increments on transfer; after byte ZB-1 transfers → RECV in the next cycle.
- Timing: with strobe in cycle S, `z` is sampled at the end of cycle S+LATENCY. For LATENCY=1 this matches the registered-output DUT.
- Back-pressure:
  - `rx_ready`=0 in every state except RECV; bytes offered then are not consumed.
  - `tx_ready` low stalls SEND indefinitely with no data loss.
- Byte count: there is no inter-frame gap requirement. Minimum turnaround from the last RX byte to the first TX byte is LATENCY+1 cycles.
- Reset (async assert, also mid-operation):
  - State → RECV; all counters → 0; shadow and capture registers → 0.
  - `a`, `b`, `c` and all control outputs → 0.
  - `strobe`, `tx_valid` → 0; `tx_data` → 0; `busy` → 0; `rx_ready` → 1 after deassertion.
  - A partially received frame is discarded.
- `strobe` is never asserted outside STROBE. Exactly one strobe is issued per completed RX frame.

Decomposition:
- Package `dut_stim_pkg`:
  - state enum {RECV, STROBE, WAIT, SEND}.
  - Control-byte bit-index constants.
  - Derived byte-count functions (AB, CB, ZB, frame length).
- No sub-module; a single FSM plus datapath.

Test Plan:
- Frame ctrl=0x10, a=0x00003, b=0x00005, c=0 with `z` driven by a bench registered-multiply model:
  - `a`=3, `b`=5, `ceout`=1 appear together on the cycle after byte 13.
  - `strobe` high exactly 1 cycle.
  - TX = 0F 00 00 00 00 00 00.
- Frame with a=0x3FFFF sent as bytes FF FF FF (upper 6 bits ignored), ctrl=0xFF:
  - `a`=0x3FFFF.
  - Control outputs = 1,1,1,1,1,1.
  - No partial output change during bytes 1–12.
- LATENCY=3, `z` model changing every cycle after strobe: captured value equals the `z` present in cycle S+3.
- `tx_ready` held low 10 cycles during SEND:
  - `tx_data` stays 0x0F; `rx_ready`=0; `rx_valid` bytes offered are not consumed.
  - After release, the remaining 6 bytes follow.
- Assert `rst` after byte 7 of a frame:
  - All outputs return to 0 immediately.
  - A fresh 14-byte frame then produces exactly one strobe and a correct 7-byte response.
- Two back-to-back frames with `rx_valid` continuously high: exactly two strobes, and the second frame's bytes are accepted only after the first TX frame completes.
